// File: rtl/id_scoreboard_pkg.sv
// Shared CPU pipeline definitions: scoreboard entry layout, stage indices and result latencies.
package id_scoreboard_pkg;

  localparam int unsigned SCB_LAT_MAXW = 4;

  typedef struct packed {
    logic                    valid;
    logic [4:0]              dst;
    logic [SCB_LAT_MAXW-1:0] lat;
  } scb_entry_t;

  localparam int unsigned STG_EXE  = 0;
  localparam int unsigned STG_MEM  = 1;
  localparam int unsigned STG_MEM2 = 2;
  localparam int unsigned STG_WB   = 3;

  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_MFC0 = 1;
  localparam int unsigned LAT_LOAD = 2;

  // 0 selects the register file, k+1 selects stage k.
  function automatic int unsigned scb_sel_width(input int unsigned nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle; master is the ID stage, slave is the scoreboard.
interface id_scoreboard_if #(
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned LATW   = 2
);
  localparam int unsigned SELW = id_scoreboard_pkg::scb_sel_width(NSTAGE);

  logic                   id_issue;
  logic                   id_rfwr;
  logic [4:0]             id_dst;
  logic [LATW-1:0]        id_lat;
  logic [NSRC*5-1:0]      id_src;
  logic [NSRC-1:0]        id_src_rd;
  logic                   pipe_adv;
  logic [NSTAGE-1:0]      flush_mask;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   id_stall;
  logic                   scb_busy;

  modport master (
    output id_issue, id_rfwr, id_dst, id_lat, id_src, id_src_rd, pipe_adv, flush_mask,
    input  fwd_sel, id_stall, scb_busy
  );

  modport slave (
    input  id_issue, id_rfwr, id_dst, id_lat, id_src, id_src_rd, pipe_adv, flush_mask,
    output fwd_sel, id_stall, scb_busy
  );
endinterface

// File: rtl/id_scoreboard_lookup.sv
// Priority match of one source operand against the in-flight entries (youngest producer wins).
module scb_operand_lookup
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned SELW   = 3
) (
  input  scb_entry_t [NSTAGE-1:0] entries,
  input  logic [4:0]              src,
  input  logic                    rd,
  output logic [SELW-1:0]         fwd_sel,
  output logic                    stall
);

  logic        hit;
  int unsigned hit_k;

  always_comb begin
    hit   = 1'b0;
    hit_k = 0;
    // Scan oldest to youngest so the lowest matching index is the one kept.
    for (int unsigned k = NSTAGE; k > 0; k--) begin
      if (entries[k-1].valid && (entries[k-1].dst == src)) begin
        hit   = 1'b1;
        hit_k = k - 1;
      end
    end
  end

  always_comb begin
    fwd_sel = '0;
    stall   = 1'b0;
    if (rd && (src != '0) && hit) begin
      if (32'(entries[hit_k].lat) <= hit_k)
        fwd_sel = SELW'(hit_k + 1);
      else
        stall = 1'b1;
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// In-flight destination tracker for ID forwarding/stall decisions.
// Optional stall-cycle performance counter enabled by defining SCB_PERF_CNT_EN.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned LATW   = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  id_scoreboard_if.slave        bus
`ifdef SCB_PERF_CNT_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned SELW = scb_sel_width(NSTAGE);

  scb_entry_t [NSTAGE-1:0] stage_q;
  scb_entry_t [NSTAGE-1:0] stage_d;
  logic [NSRC-1:0]         op_stall;
  logic [NSRC*SELW-1:0]    fwd_vec;
  logic                    stall;
  logic                    busy;

  for (genvar i = 0; i < NSRC; i++) begin : g_lookup
    scb_operand_lookup #(
      .NSTAGE (NSTAGE),
      .SELW   (SELW)
    ) u_lookup (
      .entries (stage_q),
      .src     (bus.id_src[i*5 +: 5]),
      .rd      (bus.id_src_rd[i]),
      .fwd_sel (fwd_vec[i*SELW +: SELW]),
      .stall   (op_stall[i])
    );
  end

  assign stall        = bus.id_issue & (|op_stall);
  assign bus.id_stall = stall;
  assign bus.fwd_sel  = fwd_vec;
  assign bus.scb_busy = busy;

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k < NSTAGE; k++)
      busy = busy | stage_q[k].valid;
  end

  // Shift first, then flush, so a flush also kills an entry issued this cycle.
  always_comb begin
    stage_d = stage_q;
    if (bus.pipe_adv) begin
      for (int unsigned k = 1; k < NSTAGE; k++)
        stage_d[k] = stage_q[k-1];
      stage_d[STG_EXE].valid = bus.id_issue & bus.id_rfwr & ~stall & (bus.id_dst != '0);
      stage_d[STG_EXE].dst   = bus.id_dst;
      stage_d[STG_EXE].lat   = SCB_LAT_MAXW'(bus.id_lat);
    end
    for (int unsigned k = 0; k < NSTAGE; k++)
      if (bus.flush_mask[k])
        stage_d[k].valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      stage_q <= '0;
    else
      stage_q <= stage_d;
  end

`ifdef SCB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn || perf_clr)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised successor to the ID-stage forward/hazard logic.
- Replaces fixed EXE/MEM/MEM2/WB comparators with a pipelined in-flight destination tracker: NSTAGE post-ID stages, NSRC source operands, per-instruction result latency.
- Each cycle it produces a forward select and a stall per operand.
- Sits in ID, beside the register file and the forward muxes.

Parameters:
- NSTAGE, 4, post-ID stages tracked (index 0 = EXE … NSTAGE-1 = WB).
- NSRC, 2, source operands looked up per cycle (3 for future 3-source ops).
- LATW, 2, width of latency field; must satisfy 2**LATW >= NSTAGE.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- id_issue  in  1  ID holds a valid instruction this cycle
- id_rfwr  in  1  ID instruction writes the register file
- id_dst  in  5  ID destination register
- id_lat  in  LATW  first stage index whose result is forwardable (ALU 0, MFC0 1, load 2)
- id_src  in  NSRC*5  source register numbers
- id_src_rd  in  NSRC  operand actually read
- pipe_adv  in  1  downstream pipeline advances this cycle
- flush_mask  in  NSTAGE  bit k clears stage k entry this cycle
- fwd_sel  out  NSRC*$clog2(NSTAGE+1)  per operand: 0 = RF, k+1 = stage k result
- id_stall  out  1  ID must hold (operand not yet available)
- scb_busy  out  1  any stage entry valid

Behaviour:
- State: NSTAGE entries {valid, dst[4:0], lat[LATW-1:0]}, shift-register style.
- Reset (resetn=0 at posedge): all valid=0. Outputs follow combinationally: fwd_sel=0, id_stall=0, scb_busy=0.
- Advance, pipe_adv=1:
  - Entry k moves to k+1. Entry NSTAGE-1 retires.
  - Stage 0 loads {id_issue & id_rfwr & !id_stall, id_dst, id_lat}.
  - A stalled ID therefore inserts a bubble into stage 0.
- pipe_adv=0: all entries hold; issue is ignored.
- Flush: flush_mask[k] invalidates the value stage k would hold after this edge (applied after the shift). Flush beats issue and advance.
- Entries with dst=0 are never written valid (treated as no write).
- Lookup, per operand i with id_src_rd[i]=1 and src≠0:
  - Find the lowest index k with valid & dst==src (youngest producer wins).
  - No match: fwd_sel=0, no stall contribution.
  - Match with lat<=k: fwd_sel=k+1.
  - Match with lat>k: stall contribution=1. fwd_sel is don't-care; drive 0.
- Operand with id_src_rd=0 or src=0: fwd_sel=0, never stalls.
- id_stall = OR of all operand stall contributions, gated by id_issue.
- Lookup is purely combinational over registered state: zero-cycle latency. An issued producer is visible to the next ID instruction one cycle after issue.
- Simultaneous cases:
  - Issue while the same register's older producer is in flight: both entries are kept; the younger one shadows the older.
  - Flush and stall in the same cycle: the flush is applied; the stall output reflects pre-edge state.
- Reset mid-operation discards all in-flight entries; no residual stall.

Optional Feature:
- Macro SCB_PERF_CNT_EN.
- When defined: adds output stall_cycles [31:0].
  - Reset 0.
  - +1 on each cycle with id_stall=1.
  - Saturates at 32'hFFFF_FFFF.
  - Also adds input perf_clr (sync clear; takes priority over increment).
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared CPU package:
  - typedef scb_entry_t {valid, dst, lat}
  - localparams STG_EXE=0, STG_MEM=1, STG_MEM2=2, STG_WB=3
  - latency constants LAT_ALU=0, LAT_MFC0=1, LAT_LOAD=2
- One sub-module, scb_operand_lookup: combinational priority match for a single operand over the entry array, giving {fwd_sel, stall}. Instantiated NSRC times in a generate loop.

Test Plan:
- After reset: id_src={5'd3,5'd4}, reads on -> fwd_sel={0,0}, id_stall=0, scb_busy=0.
- ALU back-to-back: issue `addu r5` (lat 0), then the next cycle issue a reader of r5 -> fwd_sel for r5 =1 (EXE), no stall.
- Load-use:
  - Issue `lw r7` (lat 2), then a reader of r7 next cycle -> id_stall=1 for 2 cycles (entry at stage 0, then 1).
  - The cycle the load entry reaches stage 2 -> fwd_sel=3, stall=0.
  - The bubbles inserted meanwhile are not valid.
- Shadowing: issue `addu r9` then `lw r9`, then a reader of r9 -> lookup picks the load at stage 0 and stalls; it does not forward the older ALU result.
- Flush: `lw r2` at stage 0 with flush_mask=4'b0001 while pipe_adv=0 -> the entry is invalid next cycle; a reader of r2 gets fwd_sel=0 with no stall.
- r0 and unread operands: issue a write to r0, then a reader with src=0; also src=r5 with id_src_rd=0 while r5 is pending -> fwd_sel=0, id_stall=0 in both cases.
- With SCB_PERF_CNT_EN: the load-use case above -> stall_cycles=2; perf_clr pulse -> 0.
